des_key_schedule_generator: RTL and testbench
=============================================

Name: des_key_schedule_generator

Overview:
- Sequential DES key-schedule engine. Loads a 64-bit key and applies PC-1 to form C/D (28+28 bits).
- Produces the 16 round subkeys (48 bits each, via PC-2) one per handshake.
  - Encrypt order: K1..K16, rotating C/D left.
  - Decrypt order: K16..K1, rotating C/D right.
- Feeds the round datapath. Because it runs in both directions, the datapath needs no separate decryption key store.

Parameters:
- PARITY_CHECK, 0, when 1 the block checks DES odd parity of each key byte at load and reports failures on key_parity_error. When 0, key_parity_error is tied 0.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- key_load  input  1  start request; accepted only while idle.
- key_input  input  [64:1]  key in FIPS 46-3 bit numbering: DES bit n is index n. Parity bits are 8, 16, ..., 64.
- decrypt_mode  input  1  sampled with key_load. 0 = K1..K16 order, 1 = K16..K1 order.
- subkey_ready  input  1  consumer accepts the current subkey.
- subkey_valid  output  1  subkey_output and subkey_index are valid.
- subkey_output  output  [48:1]  PC-2 of the current C/D, DES bit numbering (index n = DES bit n).
- subkey_index  output  [4:0]  DES round number (1..16) of the presented subkey. 0 when idle.
- busy  output  1  high from the key_load accept until the last subkey is accepted.
- schedule_done  output  1  single-cycle pulse, the cycle after the 16th subkey is accepted.
- key_parity_error  output  1  registered at load. Stays set until the next accepted key_load or reset.

Behaviour:
- Reset (async, any time, including mid-schedule) forces the following. Processing resumes only on a new key_load after reset deasserts.
  - State IDLE; C/D cleared; subkey_valid = 0; subkey_index = 0; busy = 0; schedule_done = 0; key_parity_error = 0.
  - subkey_output = PC-2 of zero C/D, which is 0.
- Shift table (by DES round 1..16): SHIFT = 1 for rounds 1, 2, 9 and 16; SHIFT = 2 for all other rounds.
- PC-1 and PC-2 are per FIPS 46-3, indexed identically to the existing permutation blocks.
- States: IDLE and RUN.
- IDLE plus key_load:
  - Encrypt: C/D <= rotl28(PC-1(key), 1) for each half; subkey_index <= 1.
  - Decrypt: C/D <= PC-1(key) unrotated (C16 = C0); subkey_index <= 16.
  - Go to RUN. subkey_valid and busy rise on the next cycle, so latency from load to first subkey is 1 cycle.
- RUN: subkey_output = PC-2(C, D), from registers only, with no combinational path from the inputs. Outputs hold stable while subkey_valid && !subkey_ready.
- Accept = subkey_valid && subkey_ready. With r = current subkey_index:
  - Encrypt, r < 16: rotate C and D left by SHIFT[r+1]; r <= r+1.
  - Decrypt, r > 1: rotate C and D right by SHIFT[r]; r <= r-1.
  - Last subkey accepted (encrypt r = 16, or decrypt r = 1): go to IDLE. subkey_valid, busy and subkey_index clear next cycle; schedule_done pulses that same next cycle.
- With subkey_ready held high, one subkey is delivered per cycle. A full schedule takes 17 cycles from key_load to schedule_done.
- key_load during RUN is ignored: no restart, and key_input is not re-sampled.
- key_load arriving in the same cycle as the final accept is also ignored. A new load is accepted from the IDLE cycle onwards, which is the schedule_done cycle.
- decrypt_mode and key_input are don't-care except in the accepting cycle.
- The parity check (PARITY_CHECK = 1) flags any byte among key bits 1..8, 9..16, ..., 57..64 with even parity.
  - The check only flags; the schedule still runs.
  - PC-1 discards the parity bits, so their values never affect any subkey.

Test Plan:
- Encrypt vector: load key 0x133457799BBCDFF1 (bench maps the hex MSB to index 1), decrypt_mode = 0, subkey_ready = 1.
  - Cycle+1: subkey_index = 1, subkey_output = 0x1B02EFFC7072 (MSB = index 1).
  - 16th subkey = 0xCB3D8B0E17F5.
  - schedule_done pulses at cycle+17.
- Decrypt vector: same key, decrypt_mode = 1.
  - First subkey has index 16 = 0xCB3D8B0E17F5; last has index 1 = 0x1B02EFFC7072.
  - All 16 subkeys equal the encrypt run in reverse order.
- Backpressure: random subkey_ready stalls. subkey_output and subkey_index stay constant while stalled; exactly 16 accepts occur; no index is skipped or repeated.
- Load while busy: key_load with a different key at round 5. Sequence continues unchanged; busy stays 1 through completion.
- Reset mid-schedule: assert reset asynchronously at round 9. Outputs go to zero immediately, without waiting for a clock edge. A new load afterwards restarts at index 1.
- Parity (PARITY_CHECK = 1): key 0x133457799BBCDFF1 (all bytes odd) gives error 0. Flipping bit 8 gives error 1 with identical subkeys.

Source files
------------

// File: rtl/des_key_schedule_generator_if.sv
// Handshake and data bundle between a DES key-schedule engine and the
// round datapath that consumes its subkeys.
interface des_key_schedule_generator_if;
  logic          key_load;
  logic [64:1]   key_input;
  logic          decrypt_mode;
  logic          subkey_ready;
  logic          subkey_valid;
  logic [48:1]   subkey_output;
  logic [4:0]    subkey_index;
  logic          busy;
  logic          schedule_done;
  logic          key_parity_error;

  // Consumer side: loads keys and accepts subkeys.
  modport master (
    output key_load,
    output key_input,
    output decrypt_mode,
    output subkey_ready,
    input  subkey_valid,
    input  subkey_output,
    input  subkey_index,
    input  busy,
    input  schedule_done,
    input  key_parity_error
  );

  // Engine side.
  modport slave (
    input  key_load,
    input  key_input,
    input  decrypt_mode,
    input  subkey_ready,
    output subkey_valid,
    output subkey_output,
    output subkey_index,
    output busy,
    output schedule_done,
    output key_parity_error
  );
endinterface

// File: rtl/des_key_schedule_generator.sv
// Sequential DES key schedule. A loaded key is reduced by PC-1 into the C/D
// halves; each accepted subkey advances C/D by the round's shift amount,
// leftwards for K1..K16 or rightwards for K16..K1, so one engine serves both
// encryption and decryption. Subkeys are PC-2 of the registered C/D only.
// All vectors use DES bit numbering: index n is DES bit n.
module des_key_schedule_generator #(
  parameter int PARITY_CHECK = 0
) (
  input logic                          clk,
  input logic                          reset,
  des_key_schedule_generator_if.slave  ks
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // PC-1, C half. The streaming reverse puts the first table entry at bit 1.
  function automatic logic [28:1] pc1_c(input logic [64:1] k);
    logic [28:1] r;
    r = {<<{k[57], k[49], k[41], k[33], k[25], k[17], k[9],
            k[1],  k[58], k[50], k[42], k[34], k[26], k[18],
            k[10], k[2],  k[59], k[51], k[43], k[35], k[27],
            k[19], k[11], k[3],  k[60], k[52], k[44], k[36]}};
    return r;
  endfunction

  // PC-1, D half.
  function automatic logic [28:1] pc1_d(input logic [64:1] k);
    logic [28:1] r;
    r = {<<{k[63], k[55], k[47], k[39], k[31], k[23], k[15],
            k[7],  k[62], k[54], k[46], k[38], k[30], k[22],
            k[14], k[6],  k[61], k[53], k[45], k[37], k[29],
            k[21], k[13], k[5],  k[28], k[20], k[12], k[4]}};
    return r;
  endfunction

  // PC-2 over the joined 56-bit C/D (C is bits 1..28, D is bits 29..56).
  function automatic logic [48:1] pc2(input logic [28:1] c, input logic [28:1] d);
    logic [56:1] cd;
    logic [48:1] r;
    cd = {d, c};
    r = {<<{cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
            cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
            cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
            cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
            cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
            cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
            cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
            cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]}};
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one position; every other round by two.
  function automatic logic shift_is_two(input logic [4:0] round);
    return !((round == 5'd1) || (round == 5'd2) ||
             (round == 5'd9) || (round == 5'd16));
  endfunction

  // DES left rotation moves bit n+1 into bit n, bit 1 wrapping to bit 28.
  function automatic logic [28:1] rot_left(input logic [28:1] x, input logic two);
    return two ? {x[2:1], x[28:3]} : {x[1], x[28:2]};
  endfunction

  // Inverse of rot_left.
  function automatic logic [28:1] rot_right(input logic [28:1] x, input logic two);
    return two ? {x[26:1], x[28:27]} : {x[27:1], x[28]};
  endfunction

  // A byte fails DES odd parity when its eight bits XOR to zero.
  function automatic logic parity_fail(input logic [64:1] k);
    return (~^k[8:1])   | (~^k[16:9])  | (~^k[24:17]) | (~^k[32:25]) |
           (~^k[40:33]) | (~^k[48:41]) | (~^k[56:49]) | (~^k[64:57]);
  endfunction

  state_t      state_p0, state_nx;
  logic [28:1] c_p0, c_nx;
  logic [28:1] d_p0, d_nx;
  logic [4:0]  idx_p0, idx_nx;
  logic        dec_p0, dec_nx;
  logic        done_p0, done_nx;
  logic        perr_p0, perr_nx;

  logic [28:1] c_load;
  logic [28:1] d_load;
  logic        perr_load;
  logic        accept;
  logic        last_round;

  assign c_load     = pc1_c(ks.key_input);
  assign d_load     = pc1_d(ks.key_input);
  assign perr_load  = (PARITY_CHECK != 0) ? parity_fail(ks.key_input) : 1'b0;
  assign accept     = (state_p0 == RUN) && ks.subkey_ready;
  assign last_round = dec_p0 ? (idx_p0 == 5'd1) : (idx_p0 == 5'd16);

  // Next-state logic: load in IDLE, advance C/D on each accepted subkey.
  always_comb begin
    state_nx = state_p0;
    c_nx     = c_p0;
    d_nx     = d_p0;
    idx_nx   = idx_p0;
    dec_nx   = dec_p0;
    done_nx  = 1'b0;
    perr_nx  = perr_p0;
    case (state_p0)
      IDLE: begin
        if (ks.key_load) begin
          state_nx = RUN;
          dec_nx   = ks.decrypt_mode;
          perr_nx  = perr_load;
          if (ks.decrypt_mode) begin
            // C16/D16 equal C0/D0: the sixteen shifts total 28 positions.
            c_nx   = c_load;
            d_nx   = d_load;
            idx_nx = 5'd16;
          end else begin
            c_nx   = rot_left(c_load, 1'b0);
            d_nx   = rot_left(d_load, 1'b0);
            idx_nx = 5'd1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (last_round) begin
            state_nx = IDLE;
            idx_nx   = 5'd0;
            done_nx  = 1'b1;
          end else if (dec_p0) begin
            // Undo the shift that produced the current round.
            c_nx   = rot_right(c_p0, shift_is_two(idx_p0));
            d_nx   = rot_right(d_p0, shift_is_two(idx_p0));
            idx_nx = idx_p0 - 5'd1;
          end else begin
            // Apply the shift that produces the next round.
            c_nx   = rot_left(c_p0, shift_is_two(idx_p0 + 5'd1));
            d_nx   = rot_left(d_p0, shift_is_two(idx_p0 + 5'd1));
            idx_nx = idx_p0 + 5'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and C/D registers; reset clears everything, including C/D.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= IDLE;
      c_p0     <= '0;
      d_p0     <= '0;
      idx_p0   <= '0;
      dec_p0   <= 1'b0;
      done_p0  <= 1'b0;
      perr_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      c_p0     <= c_nx;
      d_p0     <= d_nx;
      idx_p0   <= idx_nx;
      dec_p0   <= dec_nx;
      done_p0  <= done_nx;
      perr_p0  <= perr_nx;
    end
  end

  assign ks.subkey_valid     = (state_p0 == RUN);
  assign ks.busy             = (state_p0 == RUN);
  assign ks.subkey_index     = idx_p0;
  assign ks.subkey_output    = pc2(c_p0, d_p0);
  assign ks.schedule_done    = done_p0;
  assign ks.key_parity_error = perr_p0;

endmodule

// File: tb/tb_des_key_schedule_generator.sv
// Self-checking bench for the DES key-schedule engine. Expected subkeys come
// from a reference model that rotates C0/D0 by the cumulative shift count.
module tb_des_key_schedule_generator;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h123457799BBCDFF1;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;
  localparam logic [47:0] K1_A    = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A   = 48'hCB3D8B0E17F5;

  typedef struct packed {
    logic [4:0]  idx;
    logic [47:0] key;
  } exp_t;

  int PC1 [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                   10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                   63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                   14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int PC2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                   23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                   41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                   44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb [$];
  logic [47:0] enc_keys [16];

  des_key_schedule_generator_if ks ();

  des_key_schedule_generator #(.PARITY_CHECK(1)) dut (
    .clk   (clk),
    .reset (reset),
    .ks    (ks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: hex MSB is DES bit 1, both for the key and the subkey.
  function automatic logic [47:0] model_subkey(input logic [63:0] key_hex, input int round);
    logic [55:0] cd0;
    logic [55:0] cdr;
    logic [55:0] rot;
    logic [63:0] t;
    logic [55:0] t56;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] res;
    int s;
    cd0 = '0;
    for (int i = 0; i < 56; i++) begin
      t = key_hex >> (64 - PC1[i]);
      cd0 = {cd0[54:0], t[0]};
    end
    s = 0;
    for (int r = 0; r < round; r++) s += SHIFTS[r];
    s = s % 28;
    rot = {cd0[55:28], cd0[55:28]} << s;
    c = rot[55:28];
    rot = {cd0[27:0], cd0[27:0]} << s;
    d = rot[55:28];
    cdr = {c, d};
    res = '0;
    for (int j = 0; j < 48; j++) begin
      t56 = cdr >> (56 - PC2[j]);
      res = {res[46:0], t56[0]};
    end
    return res;
  endfunction

  function automatic exp_t sb_pop();
    exp_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  // Drives one key_load cycle and queues the 16 subkeys it should produce.
  task automatic load_key(input logic [63:0] h, input logic dec);
    exp_t e;
    int rr;
    @(negedge clk);
    ks.key_load     = 1'b1;
    ks.key_input    = {<<{h}};
    ks.decrypt_mode = dec;
    for (int r = 0; r < 16; r++) begin
      rr = dec ? (16 - r) : (r + 1);
      e.idx = rr[4:0];
      e.key = model_subkey(h, rr);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    ks.key_load     = 1'b0;
    ks.key_input    = '0;
    ks.decrypt_mode = 1'b0;
    ks.subkey_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ks.subkey_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ks.subkey_valid); end
    checks++; if (ks.subkey_index !== 5'd0) begin failures++; $display("FAIL rst_index got=%0d exp=0", ks.subkey_index); end
    checks++; if (ks.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", ks.busy); end
    checks++; if (ks.schedule_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", ks.schedule_done); end
    checks++; if (ks.key_parity_error !== 1'b0) begin failures++; $display("FAIL rst_perr got=%b exp=0", ks.key_parity_error); end
    checks++; if (ks.subkey_output !== 48'd0) begin failures++; $display("FAIL rst_subkey got=%h exp=0", ks.subkey_output); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_encrypt();
    exp_t e;
    logic [47:0] got;
    load_key(KEY_A, 1'b0);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      ks.key_load = 1'b0;
      ks.subkey_ready = 1'b1;
      #1;
      got = {<<{ks.subkey_output}};
      e = sb_pop();
      checks++; if (ks.subkey_index !== e.idx) begin failures++; $display("FAIL enc_index cyc=%0d got=%0d exp=%0d", cyc, ks.subkey_index, e.idx); end
      checks++; if (got !== e.key) begin failures++; $display("FAIL enc_subkey cyc=%0d got=%h exp=%h", cyc, got, e.key); end
      checks++; if (ks.subkey_valid !== 1'b1 || ks.busy !== 1'b1 || ks.schedule_done !== 1'b0) begin
        failures++; $display("FAIL enc_ctrl cyc=%0d valid=%b busy=%b done=%b exp=1,1,0", cyc, ks.subkey_valid, ks.busy, ks.schedule_done);
      end
      enc_keys[cyc-1] = got;
    end
    checks++; if (enc_keys[0] !== K1_A) begin failures++; $display("FAIL enc_k1_vector got=%h exp=%h", enc_keys[0], K1_A); end
    checks++; if (enc_keys[15] !== K16_A) begin failures++; $display("FAIL enc_k16_vector got=%h exp=%h", enc_keys[15], K16_A); end
    @(negedge clk);
    #1;
    checks++; if (ks.schedule_done !== 1'b1 || ks.subkey_valid !== 1'b0 || ks.busy !== 1'b0 || ks.subkey_index !== 5'd0) begin
      failures++; $display("FAIL enc_done done=%b valid=%b busy=%b idx=%0d exp=1,0,0,0", ks.schedule_done, ks.subkey_valid, ks.busy, ks.subkey_index);
    end
    @(negedge clk);
    #1;
    checks++; if (ks.schedule_done !== 1'b0) begin failures++; $display("FAIL enc_done_pulse got=%b exp=0", ks.schedule_done); end
  endtask

  task automatic test_decrypt();
    exp_t e;
    logic [47:0] got;
    load_key(KEY_A, 1'b1);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      ks.key_load = 1'b0;
      ks.subkey_ready = 1'b1;
      #1;
      got = {<<{ks.subkey_output}};
      e = sb_pop();
      checks++; if (ks.subkey_index !== e.idx) begin failures++; $display("FAIL dec_index cyc=%0d got=%0d exp=%0d", cyc, ks.subkey_index, e.idx); end
      checks++; if (got !== e.key) begin failures++; $display("FAIL dec_subkey cyc=%0d got=%h exp=%h", cyc, got, e.key); end
      checks++; if (got !== enc_keys[16-cyc]) begin failures++; $display("FAIL dec_reverse cyc=%0d got=%h exp=%h", cyc, got, enc_keys[16-cyc]); end
      if (cyc == 1) begin
        checks++; if (got !== K16_A) begin failures++; $display("FAIL dec_first got=%h exp=%h", got, K16_A); end
      end
      if (cyc == 16) begin
        checks++; if (got !== K1_A) begin failures++; $display("FAIL dec_last got=%h exp=%h", got, K1_A); end
      end
    end
    @(negedge clk);
    #1;
    checks++; if (ks.schedule_done !== 1'b1 || ks.subkey_valid !== 1'b0 || ks.subkey_index !== 5'd0) begin
      failures++; $display("FAIL dec_done done=%b valid=%b idx=%0d exp=1,0,0", ks.schedule_done, ks.subkey_valid, ks.subkey_index);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [47:0] got;
    logic [47:0] hold_key;
    logic [4:0]  hold_idx;
    bit holding;
    bit finished;
    int accepts;
    int stalls;
    holding  = 1'b0;
    finished = 1'b0;
    accepts  = 0;
    stalls   = 0;
    load_key(KEY_B, 1'b0);
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      ks.key_load = 1'b0;
      ks.subkey_ready = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      got = {<<{ks.subkey_output}};
      if (holding) begin
        checks++; if (ks.subkey_index !== hold_idx || got !== hold_key) begin
          failures++; $display("FAIL bp_hold cyc=%0d idx=%0d key=%h exp idx=%0d key=%h", cyc, ks.subkey_index, got, hold_idx, hold_key);
        end
      end
      holding = 1'b0;
      if (ks.schedule_done === 1'b1) finished = 1'b1;
      else if (ks.subkey_valid === 1'b1) begin
        if (ks.subkey_ready) begin
          accepts++;
          e = sb_pop();
          checks++; if (ks.subkey_index !== e.idx || got !== e.key) begin
            failures++; $display("FAIL bp_accept n=%0d idx=%0d key=%h exp idx=%0d key=%h", accepts, ks.subkey_index, got, e.idx, e.key);
          end
        end else begin
          stalls++;
          holding  = 1'b1;
          hold_idx = ks.subkey_index;
          hold_key = got;
        end
      end
    end
    checks++; if (!finished) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (accepts != 16) begin failures++; $display("FAIL bp_accepts got=%0d exp=16", accepts); end
    checks++; if (stalls == 0) begin failures++; $display("FAIL bp_stalls got=0 exp=>0"); end
    sb.delete();
  endtask

  task automatic test_load_while_busy();
    exp_t e;
    logic [47:0] got;
    load_key(KEY_A, 1'b0);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      ks.subkey_ready = 1'b1;
      // Intrusive loads at round 5 and in the final-accept cycle.
      ks.key_load     = (cyc == 5) || (cyc == 16);
      ks.key_input    = {<<{KEY_B}};
      ks.decrypt_mode = 1'b1;
      #1;
      got = {<<{ks.subkey_output}};
      e = sb_pop();
      checks++; if (ks.subkey_index !== e.idx || got !== e.key) begin
        failures++; $display("FAIL lwb_subkey cyc=%0d idx=%0d key=%h exp idx=%0d key=%h", cyc, ks.subkey_index, got, e.idx, e.key);
      end
      checks++; if (ks.busy !== 1'b1) begin failures++; $display("FAIL lwb_busy cyc=%0d got=%b exp=1", cyc, ks.busy); end
    end
    @(negedge clk);
    ks.key_load = 1'b0;
    ks.decrypt_mode = 1'b0;
    #1;
    checks++; if (ks.schedule_done !== 1'b1 || ks.subkey_valid !== 1'b0 || ks.busy !== 1'b0) begin
      failures++; $display("FAIL lwb_done done=%b valid=%b busy=%b exp=1,0,0", ks.schedule_done, ks.subkey_valid, ks.busy);
    end
    @(negedge clk);
    #1;
    checks++; if (ks.subkey_valid !== 1'b0 || ks.subkey_index !== 5'd0) begin
      failures++; $display("FAIL lwb_no_restart valid=%b idx=%0d exp=0,0", ks.subkey_valid, ks.subkey_index);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [47:0] got;
    load_key(KEY_A, 1'b0);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      ks.key_load = 1'b0;
      ks.subkey_ready = 1'b1;
      #1;
      got = {<<{ks.subkey_output}};
      e = sb_pop();
      checks++; if (ks.subkey_index !== e.idx || got !== e.key) begin
        failures++; $display("FAIL b2b_first cyc=%0d idx=%0d key=%h exp idx=%0d key=%h", cyc, ks.subkey_index, got, e.idx, e.key);
      end
    end
    // Reload in the schedule_done cycle.
    load_key(KEY_B, 1'b1);
    #1;
    checks++; if (ks.schedule_done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", ks.schedule_done); end
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      ks.key_load = 1'b0;
      #1;
      got = {<<{ks.subkey_output}};
      e = sb_pop();
      checks++; if (ks.subkey_valid !== 1'b1 || ks.subkey_index !== e.idx || got !== e.key) begin
        failures++; $display("FAIL b2b_second cyc=%0d valid=%b idx=%0d key=%h exp idx=%0d key=%h", cyc, ks.subkey_valid, ks.subkey_index, got, e.idx, e.key);
      end
    end
    @(negedge clk);
    #1;
    checks++; if (ks.schedule_done !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", ks.schedule_done); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [47:0] got;
    load_key(KEY_A, 1'b0);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      ks.key_load = 1'b0;
      ks.subkey_ready = 1'b1;
      #1;
      got = {<<{ks.subkey_output}};
      e = sb_pop();
      checks++; if (ks.subkey_index !== e.idx || got !== e.key) begin
        failures++; $display("FAIL rmid_pre cyc=%0d idx=%0d key=%h exp idx=%0d key=%h", cyc, ks.subkey_index, got, e.idx, e.key);
      end
    end
    // Mid-cycle, well clear of the next rising edge.
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ks.subkey_valid !== 1'b0 || ks.busy !== 1'b0 || ks.subkey_index !== 5'd0 || ks.subkey_output !== 48'd0) begin
      failures++; $display("FAIL rmid_async valid=%b busy=%b idx=%0d key=%h exp all zero", ks.subkey_valid, ks.busy, ks.subkey_index, ks.subkey_output);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (ks.subkey_valid !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%b exp=0", ks.subkey_valid); end
    load_key(KEY_A, 1'b0);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      ks.key_load = 1'b0;
      #1;
      got = {<<{ks.subkey_output}};
      e = sb_pop();
      checks++; if (ks.subkey_index !== e.idx || got !== e.key) begin
        failures++; $display("FAIL rmid_restart cyc=%0d idx=%0d key=%h exp idx=%0d key=%h", cyc, ks.subkey_index, got, e.idx, e.key);
      end
    end
    @(negedge clk);
    #1;
    checks++; if (ks.schedule_done !== 1'b1) begin failures++; $display("FAIL rmid_done got=%b exp=1", ks.schedule_done); end
  endtask

  task automatic test_parity();
    exp_t e;
    logic [47:0] got;
    load_key(KEY_A, 1'b0);
    sb.delete();
    @(negedge clk);
    ks.key_load = 1'b0;
    #1;
    checks++; if (ks.key_parity_error !== 1'b0) begin failures++; $display("FAIL par_good got=%b exp=0", ks.key_parity_error); end
    repeat (17) @(negedge clk);
    load_key(KEY_BAD, 1'b0);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      ks.key_load = 1'b0;
      #1;
      got = {<<{ks.subkey_output}};
      e = sb_pop();
      checks++; if (ks.key_parity_error !== 1'b1) begin failures++; $display("FAIL par_bad cyc=%0d got=%b exp=1", cyc, ks.key_parity_error); end
      checks++; if (got !== enc_keys[cyc-1] || ks.subkey_index !== e.idx) begin
        failures++; $display("FAIL par_subkey cyc=%0d idx=%0d key=%h exp idx=%0d key=%h", cyc, ks.subkey_index, got, e.idx, enc_keys[cyc-1]);
      end
    end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ks.key_parity_error !== 1'b1) begin failures++; $display("FAIL par_sticky got=%b exp=1", ks.key_parity_error); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ks.key_parity_error !== 1'b0) begin failures++; $display("FAIL par_reset got=%b exp=0", ks.key_parity_error); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_load_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
